vram_responder: RTL and testbench
=================================

// Module: vram_responder
// PURPOSE
//  Target side of the VRAM bus: the FPGA behaves as the two VRAM byte-lane SRAMs
//  and answers vrd_n / vawr_n / vbwr_n strobes from an external initiator
//  (PPU or a bring-up master) by storing and returning bytes. Used to bring up
//  PPU VRAM accesses with the real SRAMs isolated.
//  Strobes are sampled through synchronisers, so it only serves slow, bench-timed cycles.
//  Not fast enough for full-speed PPU timing.
// PARAMETERS
//  ADDR_BITS  10  word address width per lane; memory is 2^ADDR_BITS x 8 per lane
//  SYNC_STAGES 2  flops in each strobe synchroniser (>=2)
// PORTS
//  clock        in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  vrd_n        in   1   read strobe, both lanes, active low
//  vawr_n       in   1   lane A write strobe, active low
//  vbwr_n       in   1   lane B write strobe, active low
//  va14         in   1   shared address bit 14
//  vaa          in   14  lane A address
//  vab          in   14  lane B address
//  vda_i, vdb_i in   8   data from pins (pin_bidir_8 .i)
//  vda_o, vdb_o out  8   data to pins (pin_bidir_8 .o)
//  vd_dir       out  1   LVL_DIR_OUTPUT while responding to a read, else LVL_DIR_INPUT
//  conflict     out  1   sticky: read and write strobe seen low together
//  rd_count     out  16  completed read cycles, saturating
//  wr_count     out  16  completed write cycles (either lane), saturating
// BEHAVIOUR
//  - Reset (async assert, sync release): vd_dir=LVL_DIR_INPUT, vda_o=vdb_o=0, conflict=0,
//    counters 0, state IDLE. Memory contents are not cleared.
//  - Lane address = {va14, vax[13:0]}[ADDR_BITS-1:0]; higher bits are ignored, so aliasing wraps.
//  - Strobes pass SYNC_STAGES flops; rd_s/awr_s/bwr_s = synchronised, active-high.
//  - Address and data pins are registered every clock; the copy from the previous clock is used.
//  - State machine (IDLE, READ, WRITE):
//    IDLE: rd_s=1 with no write strobe -> issue BRAM read of both lanes, go READ.
//          awr_s|bwr_s=1 with rd_s=0 -> go WRITE. Both -> conflict<=1, stay IDLE.
//    READ: vd_dir=LVL_DIR_OUTPUT from the 1st READ cycle (one clock after the BRAM read);
//          vda_o/vdb_o hold the read data.
//          Re-read each cycle so address changes during the strobe are followed one clock later.
//          rd_s=0 -> vd_dir=LVL_DIR_INPUT that same edge, rd_count+1, go IDLE.
//          Write strobe during READ -> conflict<=1, no write.
//    WRITE: latch per lane the last address/data captured while its strobe was active.
//          When the strobe is deasserted in sync (rising edge), commit that lane
//          (last value wins).
//          Go IDLE when awr_s=bwr_s=0; wr_count+1 per WRITE visit.
//          Lanes overlapping = one visit.
//          rd_s=1 in WRITE -> conflict<=1; the pending commit still happens.
//  - Latency: pin vrd_n fall -> vd_dir drive = SYNC_STAGES+2 clocks;
//    pin vrd_n rise -> release = SYNC_STAGES+1 clocks.
//  - Counters saturate at 16'hFFFF. conflict is cleared only by reset.
//  - Async reset during WRITE drops the uncommitted write.
//    Reset during READ releases the bus immediately.
// CONFIGURATION
//  VRAM_RESPONDER_COUNTERS_EN defined: rd_count/wr_count as above.
//  Not defined: counter registers are not built, rd_count/wr_count tie to 16'd0;
//    all other behaviour is identical.
// TESTING
//  1 Write A: vaa=0x0005,va14=0,vda=0xA5, vawr_n low 6 clk then high -> mem A[5]=0xA5,
//    wr_count=1, vd_dir stays INPUT.
//  2 Read back: vaa=vab=0x0005, vrd_n low 8 clk -> within 4 clk vd_dir=OUTPUT,
//    vda_o=0xA5 (vdb_o=B[5]).
//    Release 3 clk after rise; rd_count=1.
//  3 Both lanes: vaa=0x10/0x3C, vab=0x11/0xC3, vawr_n&vbwr_n low together -> A[0x10]=0x3C,
//    B[0x11]=0xC3, wr_count+1.
//  4 Alias: write 0x77 at {va14=1,vaa=0x0405} with ADDR_BITS=10 -> read at vaa=0x0005 returns 0x77.
//  5 Conflict: vrd_n and vawr_n low same clk from IDLE -> conflict=1, no memory change,
//    vd_dir INPUT. Stays 1 until reset.
//  6 Reset mid-read: drop reset while vd_dir=OUTPUT -> vd_dir=INPUT,
//    counters 0 without waiting for a clock.
//    Macro off: counters read 0 after test 1.

Source files
------------

// File: rtl/vram_responder.sv
// Stands in for the two VRAM byte-lane SRAMs: answers slow, synchronised vrd_n/vawr_n/vbwr_n strobes from block RAM.
// Optional saturating transaction counters are built when VRAM_RESPONDER_COUNTERS_EN is defined.
module vram_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vrd_n,
  input  logic        vawr_n,
  input  logic        vbwr_n,
  input  logic        va14,
  input  logic [13:0] vaa,
  input  logic [13:0] vab,
  input  logic [7:0]  vda_i,
  input  logic [7:0]  vdb_i,
  output logic [7:0]  vda_o,
  output logic [7:0]  vdb_o,
  output logic        vd_dir,
  output logic        conflict,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam logic LVL_DIR_INPUT  = 1'b0;
  localparam logic LVL_DIR_OUTPUT = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  logic [SYNC_STAGES-1:0] rd_sync_q, awr_sync_q, bwr_sync_q;
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      rd_sync_q  <= '0;
      awr_sync_q <= '0;
      bwr_sync_q <= '0;
    end else begin
      rd_sync_q  <= {rd_sync_q[SYNC_STAGES-2:0], ~vrd_n};
      awr_sync_q <= {awr_sync_q[SYNC_STAGES-2:0], ~vawr_n};
      bwr_sync_q <= {bwr_sync_q[SYNC_STAGES-2:0], ~vbwr_n};
    end
  end

  logic       rd_s;
  logic [1:0] wr_s;
  assign rd_s = rd_sync_q[SYNC_STAGES-1];
  assign wr_s = {bwr_sync_q[SYNC_STAGES-1], awr_sync_q[SYNC_STAGES-1]};

  // Truncating the 15-bit lane address makes higher addresses alias.
  logic [ADDR_BITS-1:0] addr_q [2];
  logic [7:0]           din_q  [2];
  always_ff @(posedge clock) begin
    addr_q[0] <= ADDR_BITS'({va14, vaa});
    addr_q[1] <= ADDR_BITS'({va14, vab});
    din_q[0]  <= vda_i;
    din_q[1]  <= vdb_i;
  end

  state_t          state_q, state_d;
  logic            conflict_q, conflict_d;
  logic            vd_dir_q, vd_dir_d;
  logic [7:0]      vda_o_q, vda_o_d, vdb_o_q, vdb_o_d;
  logic            rd_en;
  logic [1:0]      latch, commit, pend;
  logic [1:0][7:0] rdata;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0]           mem [2**ADDR_BITS];
    logic [7:0]           rdata_q;
    logic                 pend_q;
    logic [ADDR_BITS-1:0] pend_addr_q;
    logic [7:0]           pend_data_q;

    always_ff @(posedge clock or negedge rst_n_int) begin
      if (!rst_n_int)      pend_q <= 1'b0;
      else if (latch[gi])  pend_q <= 1'b1;
      else if (commit[gi]) pend_q <= 1'b0;
    end

    always_ff @(posedge clock) begin
      if (latch[gi]) begin
        pend_addr_q <= addr_q[gi];
        pend_data_q <= din_q[gi];
      end
    end

    always_ff @(posedge clock) begin
      if (commit[gi]) mem[pend_addr_q] <= pend_data_q;
      if (rd_en)      rdata_q <= mem[addr_q[gi]];
    end

    assign pend[gi]  = pend_q;
    assign rdata[gi] = rdata_q;
  end

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= S_IDLE;
      conflict_q <= 1'b0;
      vd_dir_q   <= LVL_DIR_INPUT;
      vda_o_q    <= 8'h00;
      vdb_o_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      conflict_q <= conflict_d;
      vd_dir_q   <= vd_dir_d;
      vda_o_q    <= vda_o_d;
      vdb_o_q    <= vdb_o_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    conflict_d = conflict_q;
    vd_dir_d   = vd_dir_q;
    vda_o_d    = vda_o_q;
    vdb_o_d    = vdb_o_q;
    rd_en      = 1'b0;
    latch      = 2'b00;
    commit     = 2'b00;
    case (state_q)
      S_IDLE: begin
        vd_dir_d = LVL_DIR_INPUT;
        if (rd_s && |wr_s) begin
          conflict_d = 1'b1;
        end else if (rd_s) begin
          rd_en   = 1'b1;
          state_d = S_READ;
        end else if (|wr_s) begin
          latch   = wr_s;
          state_d = S_WRITE;
        end
      end
      S_READ: begin
        if (|wr_s) conflict_d = 1'b1;
        if (rd_s) begin
          rd_en    = 1'b1;
          vd_dir_d = LVL_DIR_OUTPUT;
          vda_o_d  = rdata[0];
          vdb_o_d  = rdata[1];
        end else begin
          vd_dir_d = LVL_DIR_INPUT;
          state_d  = S_IDLE;
        end
      end
      S_WRITE: begin
        vd_dir_d = LVL_DIR_INPUT;
        if (rd_s) conflict_d = 1'b1;
        // A lane commits on the cycle its synchronised strobe drops; the last latched value wins.
        latch  = wr_s;
        commit = ~wr_s & pend;
        if (wr_s == 2'b00) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign vd_dir   = vd_dir_q;
  assign vda_o    = vda_o_q;
  assign vdb_o    = vdb_o_q;
  assign conflict = conflict_q;

`ifdef VRAM_RESPONDER_COUNTERS_EN
  logic        rd_inc, wr_inc;
  logic [15:0] rd_cnt_q, wr_cnt_q;
  assign rd_inc = (state_q == S_READ) && !rd_s;
  assign wr_inc = (state_q == S_WRITE) && (wr_s == 2'b00);

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      if (rd_inc && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (wr_inc && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_vram_responder.sv
// Directed bench for vram_responder: scoreboard of expected read bytes, latency, aliasing, conflict and reset checks.
module tb_vram_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        vrd_n = 1'b1, vawr_n = 1'b1, vbwr_n = 1'b1, va14 = 1'b0;
  logic [13:0] vaa = '0, vab = '0;
  logic [7:0]  vda_i = '0, vdb_i = '0;
  logic [7:0]  vda_o, vdb_o;
  logic        vd_dir, conflict;
  logic [15:0] rd_count, wr_count;

  vram_responder #(.ADDR_BITS(10), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .vrd_n(vrd_n), .vawr_n(vawr_n), .vbwr_n(vbwr_n),
    .va14(va14), .vaa(vaa), .vab(vab), .vda_i(vda_i), .vdb_i(vdb_i),
    .vda_o(vda_o), .vdb_o(vdb_o), .vd_dir(vd_dir), .conflict(conflict),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         b_known;
  } exp_t;
  exp_t sb[$];

  logic [7:0] model_a [1024];
  logic [7:0] model_b [1024];
  bit         known_b [1024];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int lane_idx(input logic a14, input logic [13:0] a);
    logic [14:0] f;
    f = {a14, a};
    return int'(f[9:0]);
  endfunction

  task automatic check_counts(input string tag);
`ifdef VRAM_RESPONDER_COUNTERS_EN
    check({tag, "_rd_count"}, 32'(rd_count), 32'(exp_rd));
    check({tag, "_wr_count"}, 32'(wr_count), 32'(exp_wr));
`else
    check({tag, "_rd_count"}, 32'(rd_count), 32'd0);
    check({tag, "_wr_count"}, 32'(wr_count), 32'd0);
`endif
  endtask

  task automatic do_write(input bit wa, input bit wb, input logic a14, input logic [13:0] aa,
                          input logic [13:0] ab, input logic [7:0] da, input logic [7:0] db);
    bit drove;
    drove = 1'b0;
    va14 = a14; vaa = aa; vab = ab; vda_i = da; vdb_i = db;
    vawr_n = ~wa; vbwr_n = ~wb;
    repeat (6) begin tick(); if (vd_dir !== 1'b0) drove = 1'b1; end
    vawr_n = 1'b1; vbwr_n = 1'b1;
    repeat (5) begin tick(); if (vd_dir !== 1'b0) drove = 1'b1; end
    if (wa) model_a[lane_idx(a14, aa)] = da;
    if (wb) begin
      model_b[lane_idx(a14, ab)] = db;
      known_b[lane_idx(a14, ab)] = 1'b1;
    end
    exp_wr++;
    $display("WRITE a=%0b b=%0b va14=%0b vaa=%h vab=%h vda=%h vdb=%h", wa, wb, a14, aa, ab, da, db);
    check("write_dir_input", 32'(drove), 32'd0);
    check_counts("write");
  endtask

  task automatic do_read(input logic a14, input logic [13:0] aa, input logic [13:0] ab);
    int   n;
    exp_t e;
    sb.push_back('{model_a[lane_idx(a14, aa)], model_b[lane_idx(a14, ab)], known_b[lane_idx(a14, ab)]});
    va14 = a14; vaa = aa; vab = ab;
    vrd_n = 1'b0;
    n = 0;
    while (vd_dir !== 1'b1 && n < 20) begin tick(); n++; end
    check("read_drive_latency", 32'(n), 32'd4);
    e = sb.pop_front();
    check("read_vda_o", 32'(vda_o), 32'(e.a));
    if (e.b_known) check("read_vdb_o", 32'(vdb_o), 32'(e.b));
    while (n < 8) begin tick(); n++; end
    vrd_n = 1'b1;
    n = 0;
    while (vd_dir !== 1'b0 && n < 20) begin tick(); n++; end
    check("read_release_latency", 32'(n), 32'd3);
    exp_rd++;
    tick();
    $display("READ va14=%0b vaa=%h vab=%h vda_o=%h vdb_o=%h", a14, aa, ab, vda_o, vdb_o);
    check_counts("read");
  endtask

  initial begin
    bit drove;
    int n;
    for (int i = 0; i < 1024; i++) known_b[i] = 1'b0;

    #2 reset = 1'b0;
    repeat (3) tick();
    check("reset_vd_dir", 32'(vd_dir), 32'd0);
    check("reset_vda_o", 32'(vda_o), 32'd0);
    check("reset_vdb_o", 32'(vdb_o), 32'd0);
    check("reset_conflict", 32'(conflict), 32'd0);
    check_counts("reset");
    reset = 1'b1;
    repeat (4) tick();

    do_write(1'b1, 1'b0, 1'b0, 14'h0005, 14'h0000, 8'hA5, 8'h00);
    do_read(1'b0, 14'h0005, 14'h0005);

    do_write(1'b1, 1'b1, 1'b0, 14'h0010, 14'h0011, 8'h3C, 8'hC3);
    do_read(1'b0, 14'h0010, 14'h0011);

    do_write(1'b1, 1'b0, 1'b1, 14'h0405, 14'h0000, 8'h77, 8'h00);
    do_read(1'b0, 14'h0005, 14'h0011);

    do_write(1'b1, 1'b0, 1'b0, 14'h0020, 14'h0000, 8'h11, 8'h00);
    drove = 1'b0;
    va14 = 1'b0; vaa = 14'h0020; vda_i = 8'h99;
    vrd_n = 1'b0; vawr_n = 1'b0;
    repeat (6) begin tick(); if (vd_dir !== 1'b0) drove = 1'b1; end
    vrd_n = 1'b1; vawr_n = 1'b1;
    repeat (5) begin tick(); if (vd_dir !== 1'b0) drove = 1'b1; end
    $display("CONFLICT vaa=%h vda=%h conflict=%0b", vaa, vda_i, conflict);
    check("conflict_set", 32'(conflict), 32'd1);
    check("conflict_dir_input", 32'(drove), 32'd0);
    check_counts("conflict");
    do_read(1'b0, 14'h0020, 14'h0011);
    check("conflict_sticky", 32'(conflict), 32'd1);

    va14 = 1'b0; vaa = 14'h0005; vab = 14'h0005;
    vrd_n = 1'b0;
    n = 0;
    while (vd_dir !== 1'b1 && n < 20) begin tick(); n++; end
    check("midread_drive", 32'(vd_dir), 32'd1);
    #2 reset = 1'b0;
    #1;
    $display("RESET mid-read vd_dir=%0b rd_count=%0d wr_count=%0d", vd_dir, rd_count, wr_count);
    check("midreset_vd_dir", 32'(vd_dir), 32'd0);
    check("midreset_conflict", 32'(conflict), 32'd0);
    check("midreset_rd_count", 32'(rd_count), 32'd0);
    check("midreset_wr_count", 32'(wr_count), 32'd0);
    vrd_n = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    repeat (6) tick();
    check("post_reset_vd_dir", 32'(vd_dir), 32'd0);
    check_counts("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
